// File: rtl/run_ctrl.sv
// run_ctrl: sequences load, core reset, run and result unload around a processor core
module run_ctrl #(
  parameter logic [7:0]  LOAD_BASE = 8'd0,
  parameter logic [7:0]  RES_BASE  = 8'd64,
  parameter logic [7:0]  RES_LEN   = 8'd32,
  parameter logic [3:0]  RST_CYC   = 4'd2,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        core_reset,
  input  logic        core_done,
  output logic        mem_sel,
  output logic        mem_wr_en,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data,
  output logic        busy,
  output logic        fin,
  output logic        timed_out,
  output logic [15:0] run_cycles
);
  typedef enum logic [2:0] {IDLE, LOAD, CRST, RUN, UNLOAD, FIN} state_t;
  state_t      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d, cnt_q, cnt_d;
  logic [15:0] cyc_q, cyc_d, cyc_inc;
  logic        to_q, to_d;
  assign cyc_inc     = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
  assign busy        = state_q != IDLE;
  assign fin         = state_q == FIN;
  assign ld_ready    = state_q == LOAD;
  assign out_valid   = state_q == UNLOAD;
  assign core_reset  = state_q == IDLE || state_q == LOAD || state_q == CRST;
  assign mem_sel     = state_q != RUN;
  assign mem_wr_en   = ld_ready && ld_valid;
  assign mem_addr    = ptr_q;
  assign mem_wr_data = ld_data;
  assign out_data    = mem_rd_data;
  assign timed_out   = to_q;
  assign run_cycles  = cyc_q;
  // phase sequencing; cnt doubles as the core-reset countdown and the unload byte count
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        ptr_d   = LOAD_BASE;
        cyc_d   = '0;
        to_d    = 1'b0;
      end
      LOAD: if (ld_valid) begin
        ptr_d = ptr_q + 8'd1;
        if (ld_last) begin
          state_d = CRST;
          cnt_d   = {4'd0, RST_CYC};
        end
      end
      CRST: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? RUN : CRST;
      end
      RUN: begin
        cyc_d = cyc_inc;
        if (core_done || cyc_inc == TIMEOUT) begin
          state_d = UNLOAD;
          ptr_d   = RES_BASE;
          cnt_d   = RES_LEN;
          to_d    = !core_done;
        end
      end
      UNLOAD: if (out_ready) begin
        ptr_d   = ptr_q + 8'd1;
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? FIN : UNLOAD;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers, cleared asynchronously so an in-flight run is abandoned at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
    end
  end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized runs checked against a transaction-level model of load, run and unload
module tb_run_ctrl;
  localparam int LOAD_BASE = 0;
  localparam int RES_BASE  = 64;
  localparam int RES_LEN   = 32;
  localparam int RST_CYC   = 2;
  localparam int TIMEOUT   = 20;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, out_ready = 1'b0, core_done = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_ready, out_valid, core_reset, mem_sel, mem_wr_en, busy, fin, timed_out;
  logic [7:0]  out_data, mem_addr, mem_wr_data, mem_rd_data;
  logic [15:0] run_cycles;
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  fixed [$];
  int          n_cmp = 0, n_bad = 0;

  run_ctrl #(.LOAD_BASE(8'(LOAD_BASE)), .RES_BASE(8'(RES_BASE)), .RES_LEN(8'(RES_LEN)),
             .RST_CYC(4'(RST_CYC)), .TIMEOUT(16'(TIMEOUT))) dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .core_reset(core_reset), .core_done(core_done), .mem_sel(mem_sel),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .busy(busy), .fin(fin), .timed_out(timed_out),
    .run_cycles(run_cycles));

  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_mem_sel"}, mem_sel, 1);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_fin"}, fin, 0);
    chk({tag, "_timed_out"}, timed_out, 0);
    chk({tag, "_run_cycles"}, run_cycles, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  // one full run: nb load bytes, core_done in RUN cycle done_at (0 = never),
  // optional reset when rst_left unload bytes remain; pre = start already raised in IDLE
  task automatic do_run(input int nb, input int done_at, input bit hold, input int rst_left, input bit pre);
    int a, n, k, c, guard, exp_len;
    bit exp_to;
    logic [7:0] d;
    exp_to  = !(done_at >= 1 && done_at <= TIMEOUT);
    exp_len = exp_to ? TIMEOUT : done_at;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
    end
    #1 chk("idle_busy", busy, 0);
    @(negedge clk);
    start = hold;
    #1 chk("load_busy", busy, 1);
    chk("load_core_reset", core_reset, 1);
    for (int i = 0; i < nb; i++) begin
      while ($urandom_range(3) == 0) begin
        ld_valid = 1'b0;
        #1 chk("load_gap_wr", mem_wr_en, 0);
        chk("load_ready", ld_ready, 1);
        @(negedge clk);
      end
      d = (i < fixed.size()) ? fixed[i] : 8'($urandom);
      a = (LOAD_BASE + i) % 256;
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = (i == nb - 1);
      #1 chk("load_wr_en", mem_wr_en, 1);
      chk("load_addr", mem_addr, a);
      chk("load_wdata", mem_wr_data, d);
      ref_mem[a] = d;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1 chk("crst_ld_ready", ld_ready, 0);
    k = 0;
    while (core_reset === 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
      #1;
    end
    chk("crst_len", k, RST_CYC);
    c = 0;
    while (out_valid !== 1'b1 && c < 100) begin
      c++;
      core_done = (c == done_at);
      chk("run_mem_sel", mem_sel, 0);
      chk("run_wr_en", mem_wr_en, 0);
      chk("run_core_reset", core_reset, 0);
      @(negedge clk);
      #1;
    end
    core_done = 1'b0;
    chk("run_len", c, exp_len);
    n = 0;
    guard = 0;
    while (n < RES_LEN && guard < 1000) begin
      guard++;
      if (rst_left >= 0 && RES_LEN - n == rst_left) begin
        out_ready = 1'b1;
        reset = 1'b0;
        #1 chk_reset_state("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        #1 chk("rst_after_busy", busy, 0);
        return;
      end
      out_ready = $urandom_range(1);
      a = (RES_BASE + n) % 256;
      chk("unl_valid", out_valid, 1);
      chk("unl_mem_sel", mem_sel, 1);
      chk("unl_addr", mem_addr, a);
      chk("unl_data", out_data, ref_mem[a]);
      if (out_ready) n++;
      @(negedge clk);
      #1;
    end
    out_ready = 1'b0;
    chk("unl_count", n, RES_LEN);
    chk("fin_pulse", fin, 1);
    chk("fin_out_valid", out_valid, 0);
    chk("fin_timed_out", timed_out, exp_to);
    chk("fin_run_cycles", run_cycles, exp_len);
    @(negedge clk);
    #1 chk("idle_fin", fin, 0);
    chk("idle_busy_after", busy, 0);
    chk("idle_timed_out_hold", timed_out, exp_to);
    chk("idle_run_cycles_hold", run_cycles, exp_len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      mem[i] <= ref_mem[i];
    end
    #2 reset = 1'b0;
    #1 chk_reset_state("por");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    #1 chk("por_start_ignored", busy, 0);
    start = 1'b0;
    reset = 1'b1;
    fixed = '{8'hA1, 8'hB2, 8'hC3};
    do_run(3, 10, 0, -1, 0);
    chk("mem0", mem[0], 8'hA1);
    chk("mem1", mem[1], 8'hB2);
    chk("mem2", mem[2], 8'hC3);
    fixed.delete();
    do_run(5, 0, 0, -1, 0);
    do_run(4, TIMEOUT, 0, -1, 0);
    do_run(258, $urandom_range(1, TIMEOUT - 1), 0, -1, 0);
    for (int r = 0; r < 4; r++) do_run($urandom_range(1, 40), $urandom_range(0, TIMEOUT + 2), 0, -1, 0);
    do_run(6, 7, 0, 5, 0);
    do_run(6, 3, 0, -1, 0);
    do_run(2, 4, 1, -1, 0);
    start = 1'b1;
    do_run(3, 5, 0, -1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter: LOAD_BASE, 8'd0, first data-memory address written by the load phase.
REQ-002 Parameter: RES_BASE, 8'd64, first data-memory address read by the unload phase.
REQ-003 Parameter: RES_LEN, 8'd32, number of result bytes unloaded; legal range is 1..255.
REQ-004 Parameter: RST_CYC, 4'd2, number of cycles core_reset is held high; legal range is 1..15.
REQ-005 Parameter: TIMEOUT, 16'hFFFF, maximum number of core run cycles before the run is aborted.
REQ-006 Port: clk, input, 1, the single clock; all state changes on the rising edge.
REQ-007 Port: reset, input, 1, asynchronous active-low reset.
REQ-008 Port: start, input, 1, request to begin a run; sampled only in IDLE.
REQ-009 Port: ld_valid / ld_ready, input / output, 1 / 1, load-stream handshake.
REQ-010 Port: ld_data, input, 8, load byte; ld_last, input, 1, marks the final load byte.
REQ-011 Port: out_valid / out_ready, output / input, 1 / 1, result-stream handshake.
REQ-012 Port: out_data, output, 8, result byte.
REQ-013 Port: core_reset, output, 1, active-high reset to the processor core.
REQ-014 Port: core_done, input, 1, the processor's done flag.
REQ-015 Port: mem_sel, output, 1; 1 means run_ctrl owns the data-memory port, 0 means the core owns it.
REQ-016 Port: mem_wr_en, output, 1; mem_addr, output, 8; mem_wr_data, output, 8.
REQ-017 Port: mem_rd_data, input, 8, combinational read of mem_addr.
REQ-018 Port: busy, output, 1; fin, output, 1; timed_out, output, 1; run_cycles, output, 16.

Function
REQ-019 States SHALL be IDLE, LOAD, CRST, RUN, UNLOAD and FIN, and busy SHALL equal (state != IDLE).
REQ-020 From IDLE, start=1 SHALL move to LOAD, set the address pointer to LOAD_BASE, and clear timed_out and run_cycles; start SHALL be ignored in every other state.
REQ-021 In LOAD, ld_ready=1, mem_sel=1, mem_wr_en=ld_valid, mem_addr=pointer and mem_wr_data=ld_data, all driven combinationally.
REQ-022 Each ld_valid&ld_ready cycle SHALL write one byte and increment the pointer modulo 256 (255 wraps to 0).
REQ-023 A transfer with ld_last=1 SHALL write its byte and move to CRST; ld_valid=0 stalls LOAD indefinitely.
REQ-024 In CRST, core_reset=1 for exactly RST_CYC cycles, then the block SHALL move to RUN; core_reset SHALL be 1 in IDLE, LOAD and CRST and 0 in RUN, UNLOAD and FIN.
REQ-025 In RUN, mem_sel=0 and mem_wr_en=0, and run_cycles SHALL increment by 1 per cycle, saturating at 16'hFFFF.
REQ-026 In RUN, core_done=1 SHALL move to UNLOAD, and the cycle in which core_done is seen SHALL be counted.
REQ-027 In RUN, if run_cycles==TIMEOUT and core_done=0, the block SHALL set timed_out=1 and move to UNLOAD; if both events occur in the same cycle, core_done wins and timed_out stays 0.
REQ-028 On entry to UNLOAD the pointer SHALL be RES_BASE and the remaining count RES_LEN.
REQ-029 In UNLOAD, mem_sel=1, mem_wr_en=0, mem_addr=pointer, out_valid=1 and out_data=mem_rd_data, with zero-cycle read latency.
REQ-030 Each out_valid&out_ready cycle SHALL advance the pointer modulo 256 and decrement the count; when the final byte transfers, the block SHALL move to FIN.
REQ-031 While out_ready=0, out_data and mem_addr SHALL hold stable.
REQ-032 FIN SHALL last one cycle with fin=1, then return to IDLE; timed_out and run_cycles SHALL hold until the next start.
REQ-033 ld_ready SHALL be 0 outside LOAD and out_valid SHALL be 0 outside UNLOAD.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, core_reset=1, mem_sel=1, mem_wr_en=0, ld_ready=0, out_valid=0, fin=0, busy=0, timed_out=0, run_cycles=0, mem_addr=0 and count=0.
REQ-035 Reset asserted mid-LOAD, mid-RUN or mid-UNLOAD SHALL abandon the run with no further memory write or stream transfer; start is next honoured in the cycle after reset is released.

Verification
REQ-036 Load of 3 bytes A1,B2,C3 (last on C3), then core_done after 10 RUN cycles -> writes to 0,1,2; core_reset high for 2 CRST cycles; run_cycles=10; RES_LEN bytes streamed from address 64 upward; fin pulses 1 cycle.
REQ-037 out_ready toggled 1,0,0,1 during UNLOAD -> no byte dropped or duplicated; out_data is stable while stalled.
REQ-038 TIMEOUT=16'd20 with core_done held 0 -> timed_out=1 after 20 RUN cycles, unload runs, and fin pulses.
REQ-039 Load of 258 bytes from LOAD_BASE=0 -> the last two writes land at addresses 0 and 1 (wrap).
REQ-040 reset pulsed low during UNLOAD with 5 bytes remaining -> out_valid=0 and IDLE at once; a subsequent start runs a clean full cycle.
REQ-041 start held high through a whole run -> exactly one run per IDLE entry, and start is ignored while busy=1.
